// File: rtl/mash111_modulator_if.sv
// Sample/output bundle between the CIC-side driver and the MASH 1-1-1 modulator.
interface mash111_modulator_if #(
   parameter int BIT_WIDTH = 4
);
   logic                 enable;
   logic [BIT_WIDTH-1:0] data_in;
   logic                 data_valid;
   logic [2:0]           mash_out;
   logic [6:0]           thermo_out;
   logic                 out_valid;

   modport master (
      output enable, data_in, data_valid,
      input  mash_out, thermo_out, out_valid
   );

   modport slave (
      input  enable, data_in, data_valid,
      output mash_out, thermo_out, out_valid
   );
endinterface

// File: rtl/mash111_modulator.sv
// Third-order MASH 1-1-1 sigma-delta modulator with 3-bit offset code and 7-bit thermometer output.
// Optional stage-3 LFSR dither is built when MASH_DITHER_EN is defined.
module mash111_modulator #(
   parameter int          BIT_WIDTH = 4,
   parameter int          ACC_WIDTH = 4,
   parameter logic [14:0] LFSR_SEED = 15'h0001
) (
   input logic                  clk,
   input logic                  rst_n,
   mash111_modulator_if.slave   bus
);
   localparam int SHIFT = ACC_WIDTH - BIT_WIDTH;

   generate
      if (ACC_WIDTH < BIT_WIDTH) begin : g_bad_acc_width
         $error("mash111_modulator: ACC_WIDTH must be >= BIT_WIDTH");
      end
      if (LFSR_SEED == 15'h0000) begin : g_bad_seed
         $error("mash111_modulator: LFSR_SEED must be nonzero");
      end
   endgenerate

   // Thermometer decode of the offset code: bit k set when code > k.
   function automatic logic [6:0] thermo_of(input logic [3:0] code);
      logic [6:0] t;
      t = 7'b0000000;
      for (int k = 0; k < 7; k++) begin
         t[k] = (code > k[3:0]);
      end
      return t;
   endfunction

   logic [ACC_WIDTH-1:0] r_s1, r_s2, r_s3;
   logic                 r_c2d, r_c3d, r_c3dd;
   logic [2:0]           r_mash;
   logic [6:0]           r_thermo;
   logic                 r_valid;

   logic                 w_step;
   logic                 w_d;
   logic [BIT_WIDTH-1:0] w_u_raw;
   logic [ACC_WIDTH-1:0] w_u;
   logic [ACC_WIDTH:0]   w_sum1, w_sum2, w_sum3;
   logic                 w_c1, w_c2, w_c3;
   logic [3:0]           w_y;
   logic [3:0]           w_code;

   assign w_step = bus.enable && bus.data_valid;

   // Adding 2^(BIT_WIDTH-1) to a two's-complement value is an MSB flip.
   assign w_u_raw = {~bus.data_in[BIT_WIDTH-1], bus.data_in[BIT_WIDTH-2:0]};
   assign w_u     = ACC_WIDTH'(w_u_raw) << SHIFT;

   assign w_sum1 = {1'b0, r_s1} + {1'b0, w_u};
   assign w_sum2 = {1'b0, r_s2} + {1'b0, w_sum1[ACC_WIDTH-1:0]};
   assign w_sum3 = {1'b0, r_s3} + {1'b0, w_sum2[ACC_WIDTH-1:0]} + {{ACC_WIDTH{1'b0}}, w_d};
   assign w_c1   = w_sum1[ACC_WIDTH];
   assign w_c2   = w_sum2[ACC_WIDTH];
   assign w_c3   = w_sum3[ACC_WIDTH];

   // Noise cancellation in 4-bit two's complement; y spans -3..+4.
   assign w_y    = {3'b000, w_c1}
                 + {3'b000, w_c2} - {3'b000, r_c2d}
                 + {3'b000, w_c3} - {2'b00, r_c3d, 1'b0} + {3'b000, r_c3dd};
   assign w_code = w_y + 4'd3;

`ifdef MASH_DITHER_EN
   logic [14:0] r_lfsr;

   assign w_d = r_lfsr[0];

   // Fibonacci LFSR for x^15+x^14+1, advancing only on processed samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= LFSR_SEED;
      end else if (w_step) begin
         r_lfsr <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
      end else begin
         r_lfsr <= r_lfsr;
      end
   end
`else
   assign w_d = 1'b0;
`endif

   // Accumulators, carry history and registered outputs all update on the step edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1     <= {ACC_WIDTH{1'b0}};
         r_s2     <= {ACC_WIDTH{1'b0}};
         r_s3     <= {ACC_WIDTH{1'b0}};
         r_c2d    <= 1'b0;
         r_c3d    <= 1'b0;
         r_c3dd   <= 1'b0;
         r_mash   <= 3'd3;
         r_thermo <= 7'b0000111;
         r_valid  <= 1'b0;
      end else if (w_step) begin
         r_s1     <= w_sum1[ACC_WIDTH-1:0];
         r_s2     <= w_sum2[ACC_WIDTH-1:0];
         r_s3     <= w_sum3[ACC_WIDTH-1:0];
         r_c2d    <= w_c2;
         r_c3d    <= w_c3;
         r_c3dd   <= r_c3d;
         r_mash   <= w_code[2:0];
         r_thermo <= thermo_of(w_code);
         r_valid  <= 1'b1;
      end else begin
         r_valid  <= 1'b0;
      end
   end

   assign bus.mash_out   = r_mash;
   assign bus.thermo_out = r_thermo;
   assign bus.out_valid  = r_valid;
endmodule

// File: tb/tb_mash111_modulator.sv
// Scoreboard bench for mash111_modulator: directed stimulus pushes expectations, a monitor pops on out_valid.
module tb_mash111_modulator;
   typedef struct packed {
      logic       exact;
      logic [2:0] mash;
   } exp_t;

`ifdef MASH_DITHER_EN
   localparam logic EX = 1'b0;
`else
   localparam logic EX = 1'b1;
`endif

   logic clk;
   logic rst_n;
   mash111_modulator_if #(.BIT_WIDTH(4)) bus ();

   mash111_modulator #(
      .BIT_WIDTH(4),
      .ACC_WIDTH(4),
      .LFSR_SEED(15'h0001)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t       q[$];
   int         checks;
   int         errors;
   int         sum_y;
   int         rmin;
   int         rmax;
   int         k;
   logic [2:0] exp_hold;
   logic       hold_known;
   logic [6:0] THERMO [8];
   logic [2:0] SEQ [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [6:0] act, input logic [6:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic step(input logic en, input logic v, input logic signed [3:0] din,
                       input logic ex, input logic [2:0] m);
      exp_t e;
      @(negedge clk);
      bus.enable     = en;
      bus.data_valid = v;
      bus.data_in    = din;
      if (en && v) begin
         e.exact = ex;
         e.mash  = m;
         q.push_back(e);
      end
   endtask

   task automatic rst_pulse();
      @(negedge clk);
      bus.enable     = 1'b0;
      bus.data_valid = 1'b0;
      rst_n          = 1'b0;
      exp_hold       = 3'd3;
      hold_known     = 1'b1;
      #1;
      chk("rst_async_mash", {4'b0000, bus.mash_out}, 7'd3);
      chk("rst_async_thermo", bus.thermo_out, 7'b0000111);
      chk("rst_async_valid", {6'b000000, bus.out_valid}, 7'd0);
      @(negedge clk);
      rst_n = 1'b1;
      k     = 0;
   endtask

   // Monitor: one sample per cycle, 1 ns after the active edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got out_valid=1 expected 0 at %0t", $time);
            end else begin
               e = q.pop_front();
               if (e.exact) begin
                  chk("mash_out", {4'b0000, bus.mash_out}, {4'b0000, e.mash});
                  chk("thermo_out", bus.thermo_out, THERMO[e.mash]);
                  exp_hold   = e.mash;
                  hold_known = 1'b1;
               end else begin
                  checks++;
                  if ($isunknown(bus.mash_out) || $isunknown(bus.thermo_out) ||
                      bus.thermo_out !== THERMO[bus.mash_out]) begin
                     errors++;
                     $display("FAIL range_out: got mash=%0h thermo=%0h expected consistent known code at %0t",
                              bus.mash_out, bus.thermo_out, $time);
                  end else begin
                     sum_y += int'(bus.mash_out) - 3;
                     if (int'(bus.mash_out) < rmin) rmin = int'(bus.mash_out);
                     if (int'(bus.mash_out) > rmax) rmax = int'(bus.mash_out);
                  end
                  hold_known = 1'b0;
               end
            end
         end else begin
            if (q.size() != 0) begin
               checks++;
               errors++;
               $display("FAIL missing_valid: got out_valid=%b expected 1 at %0t", bus.out_valid, $time);
               void'(q.pop_front());
            end
            if (hold_known) begin
               chk("hold_mash", {4'b0000, bus.mash_out}, {4'b0000, exp_hold});
               chk("hold_thermo", bus.thermo_out, THERMO[exp_hold]);
            end
         end
      end
   end

   initial begin
      THERMO = '{7'h00, 7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F};
      SEQ    = '{3'd3, 3'd5, 3'd2, 3'd4};
      checks = 0;
      errors = 0;
      sum_y  = 0;
      rmin   = 7;
      rmax   = 0;
      k      = 0;
      exp_hold   = 3'd3;
      hold_known = 1'b1;
      rst_n          = 1'b0;
      bus.enable     = 1'b0;
      bus.data_valid = 1'b0;
      bus.data_in    = 4'sd0;

      repeat (2) @(negedge clk);
      chk("reset_mash", {4'b0000, bus.mash_out}, 7'd3);
      chk("reset_thermo", bus.thermo_out, 7'b0000111);
      chk("reset_valid", {6'b000000, bus.out_valid}, 7'd0);
      rst_n = 1'b1;

      // Minimum input: y stays 0.
      for (int i = 0; i < 32; i++) step(1'b1, 1'b1, -4'sd8, EX, 3'd3);

      // Mid-scale input: period-4 pattern 3,5,2,4.
      k = 0;
      for (int i = 0; i < 12; i++) begin
         step(1'b1, 1'b1, 4'sd0, EX, SEQ[k % 4]);
         k++;
      end

      // Gaps from data_valid low, then from enable low.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, (i % 2) == 0, 4'sd0, EX, SEQ[k % 4]);
         if ((i % 2) == 0) k++;
      end
      for (int i = 0; i < 8; i++) begin
         step((i % 2) == 0, 1'b1, 4'sd0, EX, SEQ[k % 4]);
         if ((i % 2) == 0) k++;
      end

      // Reset mid-stream, then the sequence restarts.
      k = 0;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 4'sd0, EX, SEQ[k % 4]);
         k++;
      end
      rst_pulse();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 4'sd0, EX, SEQ[k % 4]);
         k++;
      end

      // Full-scale input: mean tracks u/16 = 15/16.
      rst_pulse();
      sum_y = 0;
      for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 4'sd7, 1'b0, 3'd0);
      rst_pulse();
      checks++;
      if (sum_y < 56 || sum_y > 64) begin
         errors++;
         $display("FAIL fullscale_sum: got %0d expected 60 +/- 4", sum_y);
      end

`ifdef MASH_DITHER_EN
      sum_y = 0;
      rmin  = 7;
      rmax  = 0;
      for (int i = 0; i < 256; i++) step(1'b1, 1'b1, -4'sd8, 1'b0, 3'd0);
      rst_pulse();
      checks++;
      if (sum_y < -4 || sum_y > 4) begin
         errors++;
         $display("FAIL dither_mean: got sum %0d expected 0 +/- 4", sum_y);
      end
      checks++;
      if (rmin == rmax) begin
         errors++;
         $display("FAIL dither_activity: got constant code %0d expected varying", rmin);
      end
`endif

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
